// File: rtl/code_packer_if.sv
// Code-in / byte-out handshake bundle for the LZW code packer.
// slave is the packer side; master is the producer/sink side.
interface code_packer_if #(
  parameter int CODE_W = 12,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
);
  logic [CODE_W-1:0] iCode;
  logic              CodeValid;
  logic              CodeReady;
  logic              CloseBuffer;
  logic [BYTE_W-1:0] oByte;
  logic              ByteValid;
  logic              ByteReady;
  logic              Done;
  logic [CNT_W-1:0]  ByteCount;

  modport slave (
    input  iCode, CodeValid, CloseBuffer, ByteReady,
    output CodeReady, oByte, ByteValid, Done, ByteCount
  );

  modport master (
    output iCode, CodeValid, CloseBuffer, ByteReady,
    input  CodeReady, oByte, ByteValid, Done, ByteCount
  );
endinterface

// File: rtl/code_packer.sv
// Packs fixed-width LZW codes MSB-first into a byte stream with valid/ready
// backpressure; on close the last partial byte is zero-padded, then Done pulses.
module code_packer #(
  parameter int CODE_W = 12,
  parameter int BYTE_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 16
) (
  input logic          Clk,
  input logic          reset,
  code_packer_if.slave bus
);
  localparam int CW = $clog2(ACC_W + 1);
  localparam logic [CW-1:0] CODE_C = CW'(CODE_W);
  localparam logic [CW-1:0] BYTE_C = CW'(BYTE_W);
  localparam logic [CW-1:0] ROOM_C = CW'(ACC_W - CODE_W);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [CW-1:0]     count, count_next;
  logic              close_pending, close_pending_next;
  logic              done, done_next;
  logic [CNT_W-1:0]  byte_count;
  logic              code_ready;
  logic              byte_valid;
  logic              accept;
  logic              emit;
  logic [CW-1:0]     emit_bits;
  logic [BYTE_W-1:0] out_byte;

  // Oldest BYTE_W bits of the accumulator; with fewer bits held they are
  // left-justified so the LSBs fill with zeros (the close-time pad byte).
  function automatic logic [BYTE_W-1:0] head_byte(input logic [ACC_W-1:0] a,
                                                  input logic [CW-1:0]    n);
    if (n >= BYTE_C)
      return BYTE_W'(a >> (n - BYTE_C));
    else
      return BYTE_W'(a << (BYTE_C - n));
  endfunction

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)
      state <= RUN;
    else
      state <= state_next;
  end

  always_comb begin
    byte_valid = (count >= BYTE_C) || (state == FLUSH && count != '0);
    code_ready = (state == RUN) && (count <= ROOM_C);
    accept     = bus.CodeValid && code_ready;
    emit       = byte_valid && bus.ByteReady;
    emit_bits  = (count >= BYTE_C) ? BYTE_C : count;
    out_byte   = byte_valid ? head_byte(acc, count) : '0;

    // Bits above count are stale; extraction is always relative to count,
    // so a new code simply shifts in below whatever is still held.
    acc_next   = accept ? {acc[ACC_W-CODE_W-1:0], bus.iCode} : acc;
    count_next = count + (accept ? CODE_C : '0) - (emit ? emit_bits : '0);

    state_next         = state;
    close_pending_next = close_pending;
    done_next          = 1'b0;
    case (state)
      RUN: begin
        if (close_pending) begin
          if (accept) begin
            state_next         = FLUSH;
            close_pending_next = 1'b0;
          end
        end else if (bus.CloseBuffer) begin
          if (!bus.CodeValid || accept)
            state_next = FLUSH;
          else
            close_pending_next = 1'b1;
        end
      end
      FLUSH: begin
        if (count_next == '0) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      count         <= '0;
      close_pending <= 1'b0;
      done          <= 1'b0;
      byte_count    <= '0;
    end else begin
      acc           <= acc_next;
      count         <= count_next;
      close_pending <= close_pending_next;
      done          <= done_next;
      byte_count    <= byte_count + CNT_W'(emit);
    end
  end

  assign bus.CodeReady = code_ready;
  assign bus.ByteValid = byte_valid;
  assign bus.oByte     = out_byte;
  assign bus.Done      = done;
  assign bus.ByteCount = byte_count;
endmodule

// File: tb/tb_code_packer.sv
// Bench for code_packer: bit-queue reference model checked every cycle plus
// directed byte-stream scenarios and randomized streams.
module tb_code_packer;
  localparam int CODE_W = 12;
  localparam int BYTE_W = 8;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 16;

  typedef logic [7:0]  bq_t[$];
  typedef logic [11:0] cq_t[$];

  logic Clk = 1'b0;
  logic reset = 1'b0;

  code_packer_if #(.CODE_W(CODE_W), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) bus();

  code_packer #(.CODE_W(CODE_W), .BYTE_W(BYTE_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending stream bits, oldest first.
  bit               m_bits[$];
  int               m_state;   // 0 running, 1 flushing, 2 finished
  bit               m_pend;
  bit               m_done;
  logic [CNT_W-1:0] m_cnt;
  bq_t              got;
  cq_t              sent;
  int               viol;
  int               n_done;
  bit               t_acc;
  string            first_msg;

  function automatic bit same(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string qstr(input bq_t a);
    string s;
    s = "";
    foreach (a[i]) s = {s, $sformatf("%02h ", a[i])};
    return s;
  endfunction

  function automatic bq_t pack(input cq_t c);
    bit         b[$];
    bq_t        r;
    logic [7:0] v;
    foreach (c[i]) for (int k = 11; k >= 0; k--) b.push_back(c[i][k]);
    while (b.size() % 8 != 0) b.push_back(1'b0);
    for (int i = 0; i < b.size(); i += 8) begin
      for (int k = 0; k < 8; k++) v[7-k] = b[i+k];
      r.push_back(v);
    end
    return r;
  endfunction

  task automatic model_clear();
    m_bits.delete();
    m_state = 0; m_pend = 0; m_done = 0; m_cnt = '0;
    got.delete(); sent.delete();
    viol = 0; n_done = 0; t_acc = 0; first_msg = "";
  endtask

  task automatic drive_idle();
    bus.iCode = '0; bus.CodeValid = 0; bus.CloseBuffer = 0; bus.ByteReady = 0;
  endtask

  task automatic apply_reset();
    @(posedge Clk); #2;
    drive_idle();
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, compare DUT against model at negedge, advance model.
  task automatic tick(input logic [11:0] code, input logic cv, input logic close, input logic br);
    logic       e_cr, e_bv, acc, xfer, dn;
    logic [7:0] e_ob;
    int         n;
    bus.iCode = code; bus.CodeValid = cv; bus.CloseBuffer = close; bus.ByteReady = br;
    e_cr = (m_state == 0) && (m_bits.size() <= 12);
    e_bv = (m_bits.size() >= 8) || (m_state == 1 && m_bits.size() > 0);
    e_ob = '0;
    for (int i = 0; i < 8; i++) if (i < m_bits.size()) e_ob[7-i] = m_bits[i];
    @(negedge Clk);
    if (bus.CodeReady !== e_cr || bus.ByteValid !== e_bv || (e_bv && bus.oByte !== e_ob) ||
        bus.Done !== m_done || bus.ByteCount !== m_cnt) begin
      if (viol == 0)
        first_msg = $sformatf("t=%0t cr=%b/%b bv=%b/%b ob=%h/%h done=%b/%b cnt=%0d/%0d", $time,
                              bus.CodeReady, e_cr, bus.ByteValid, e_bv, bus.oByte, e_ob,
                              bus.Done, m_done, bus.ByteCount, m_cnt);
      viol++;
    end
    if (bus.Done === 1'b1) n_done++;
    acc  = cv && e_cr;
    xfer = e_bv && br;
    t_acc = acc;
    if (xfer) begin
      got.push_back(bus.oByte);
      n = (m_bits.size() < 8) ? m_bits.size() : 8;
      repeat (n) void'(m_bits.pop_front());
      m_cnt++;
    end
    dn = 1'b0;
    case (m_state)
      0: begin
        if (m_pend) begin
          if (acc) begin m_state = 1; m_pend = 0; end
        end else if (close) begin
          if (!cv || acc) m_state = 1;
          else m_pend = 1;
        end
      end
      1: if (m_bits.size() == 0) begin m_state = 2; dn = 1'b1; end
      default: ;
    endcase
    if (acc) begin
      for (int k = 11; k >= 0; k--) m_bits.push_back(code[k]);
      sent.push_back(code);
    end
    m_done = dn;
    @(posedge Clk); #1;
  endtask

  task automatic drain(input bit rnd, output bit timed_out);
    int post;
    post = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick('0, 1'b0, 1'b0, rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (m_state == 2) post++;
      if (post >= 3) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    @(posedge Clk); #2;
    reset = 1'b1;
    #1;
    total++; if (bus.ByteValid !== 1'b0) begin bad++; $display("FAIL reset_bv: got %b want 0", bus.ByteValid); end
    total++; if (bus.oByte !== 8'h00) begin bad++; $display("FAIL reset_obyte: got %h want 00", bus.oByte); end
    total++; if (bus.CodeReady !== 1'b1) begin bad++; $display("FAIL reset_cr: got %b want 1", bus.CodeReady); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    total++; if (bus.ByteCount !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.ByteCount); end
    @(posedge Clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_two_codes();
    bq_t e;
    bit  to;
    apply_reset();
    tick(12'hABC, 1, 0, 1);
    tick(12'h123, 1, 0, 1);
    tick(12'h000, 0, 1, 1);
    drain(0, to);
    e = '{8'hAB, 8'hC1, 8'h23};
    total++; if (to) begin bad++; $display("FAIL two_timeout: no Done within budget"); end
    total++; if (!same(got, e)) begin bad++; $display("FAIL two_bytes: got %s want %s", qstr(got), qstr(e)); end
    total++; if (bus.ByteCount !== 16'd3) begin bad++; $display("FAIL two_cnt: got %0d want 3", bus.ByteCount); end
    total++; if (n_done != 1) begin bad++; $display("FAIL two_done: got %0d pulses want 1", n_done); end
    total++; if (viol != 0) begin bad++; $display("FAIL two_cycle: %0d bad cycles, first %s", viol, first_msg); end
  endtask

  task automatic test_pad();
    bq_t e;
    bit  to;
    apply_reset();
    tick(12'h041, 1, 0, 1);
    tick(12'h000, 0, 1, 1);
    drain(0, to);
    e = '{8'h04, 8'h10};
    total++; if (to) begin bad++; $display("FAIL pad_timeout: no Done within budget"); end
    total++; if (!same(got, e)) begin bad++; $display("FAIL pad_bytes: got %s want %s", qstr(got), qstr(e)); end
    total++; if (bus.ByteCount !== 16'd2) begin bad++; $display("FAIL pad_cnt: got %0d want 2", bus.ByteCount); end
    total++; if (n_done != 1) begin bad++; $display("FAIL pad_done: got %0d pulses want 1", n_done); end
    total++; if (viol != 0) begin bad++; $display("FAIL pad_cycle: %0d bad cycles, first %s", viol, first_msg); end
  endtask

  task automatic test_back_to_back();
    bq_t e;
    bit  to;
    int  acc_n, cyc;
    apply_reset();
    acc_n = 0; cyc = 0;
    while (acc_n < 8 && cyc < 200) begin
      tick(12'hFFF, 1, 0, cyc >= 6);
      if (t_acc) acc_n++;
      cyc++;
      if (cyc == 6) begin
        total++; if (acc_n != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", acc_n); end
        total++; if (bus.CodeReady !== 1'b0) begin bad++; $display("FAIL bp_cr: got %b want 0", bus.CodeReady); end
        total++; if (bus.ByteValid !== 1'b1) begin bad++; $display("FAIL bp_bv: got %b want 1", bus.ByteValid); end
        total++; if (bus.oByte !== 8'hFF) begin bad++; $display("FAIL bp_obyte: got %h want ff", bus.oByte); end
      end
    end
    tick(12'h000, 0, 1, 1);
    drain(0, to);
    e = {};
    repeat (12) e.push_back(8'hFF);
    total++; if (to || acc_n != 8) begin bad++; $display("FAIL bp_timeout: accepted %0d want 8, timeout %b", acc_n, to); end
    total++; if (!same(got, e)) begin bad++; $display("FAIL bp_bytes: got %s want %s", qstr(got), qstr(e)); end
    total++; if (bus.ByteCount !== 16'd12) begin bad++; $display("FAIL bp_cnt: got %0d want 12", bus.ByteCount); end
    total++; if (viol != 0) begin bad++; $display("FAIL bp_cycle: %0d bad cycles, first %s", viol, first_msg); end
  endtask

  task automatic test_close_pending();
    bq_t e;
    bit  to, took;
    apply_reset();
    tick(12'hABC, 1, 0, 0);
    tick(12'h123, 1, 0, 0);
    total++; if (bus.CodeReady !== 1'b0) begin bad++; $display("FAIL pend_cr: got %b want 0", bus.CodeReady); end
    tick(12'h456, 1, 1, 0);
    took = 1'b0;
    for (int c = 0; c < 20 && !took; c++) begin
      tick(12'h456, 1, 0, 1);
      took = t_acc;
    end
    drain(0, to);
    e = '{8'hAB, 8'hC1, 8'h23, 8'h45, 8'h60};
    total++; if (to || !took) begin bad++; $display("FAIL pend_timeout: accepted %b timeout %b", took, to); end
    total++; if (!same(got, e)) begin bad++; $display("FAIL pend_bytes: got %s want %s", qstr(got), qstr(e)); end
    total++; if (bus.ByteCount !== 16'd5) begin bad++; $display("FAIL pend_cnt: got %0d want 5", bus.ByteCount); end
    total++; if (n_done != 1) begin bad++; $display("FAIL pend_done: got %0d pulses want 1", n_done); end
    total++; if (viol != 0) begin bad++; $display("FAIL pend_cycle: %0d bad cycles, first %s", viol, first_msg); end
  endtask

  task automatic test_async_reset();
    bq_t e;
    bit  to;
    apply_reset();
    tick(12'hA5A, 1, 0, 0);
    tick(12'h5A5, 1, 0, 1);
    tick(12'h000, 0, 0, 1);
    tick(12'hC3C, 1, 0, 0);
    total++; if (m_bits.size() != 20 || bus.ByteValid !== 1'b1) begin
      bad++; $display("FAIL ar_setup: bits %0d want 20, bv %b want 1", m_bits.size(), bus.ByteValid); end
    #2;
    drive_idle();
    reset = 1'b1;
    #1;
    total++; if (bus.ByteValid !== 1'b0) begin bad++; $display("FAIL ar_bv: got %b want 0", bus.ByteValid); end
    total++; if (bus.oByte !== 8'h00) begin bad++; $display("FAIL ar_obyte: got %h want 00", bus.oByte); end
    total++; if (bus.CodeReady !== 1'b1) begin bad++; $display("FAIL ar_cr: got %b want 1", bus.CodeReady); end
    total++; if (bus.ByteCount !== 16'd0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", bus.ByteCount); end
    @(posedge Clk); #1;
    reset = 1'b0;
    model_clear();
    tick(12'h800, 1, 0, 1);
    tick(12'h000, 0, 1, 1);
    drain(0, to);
    e = '{8'h80, 8'h00};
    total++; if (to) begin bad++; $display("FAIL ar_timeout: no Done within budget"); end
    total++; if (!same(got, e)) begin bad++; $display("FAIL ar_bytes: got %s want %s", qstr(got), qstr(e)); end
    total++; if (bus.ByteCount !== 16'd2) begin bad++; $display("FAIL ar_cnt2: got %0d want 2", bus.ByteCount); end
    total++; if (viol != 0) begin bad++; $display("FAIL ar_cycle: %0d bad cycles, first %s", viol, first_msg); end
  endtask

  task automatic test_close_empty();
    bit to;
    apply_reset();
    tick(12'h000, 0, 1, 1);
    drain(0, to);
    repeat (3) tick(12'h5A5, 1, 0, 1);
    total++; if (to) begin bad++; $display("FAIL empty_timeout: no Done within budget"); end
    total++; if (got.size() != 0) begin bad++; $display("FAIL empty_bytes: got %s want none", qstr(got)); end
    total++; if (n_done != 1) begin bad++; $display("FAIL empty_done: got %0d pulses want 1", n_done); end
    total++; if (bus.ByteCount !== 16'd0) begin bad++; $display("FAIL empty_cnt: got %0d want 0", bus.ByteCount); end
    total++; if (bus.CodeReady !== 1'b0) begin bad++; $display("FAIL empty_cr: got %b want 0", bus.CodeReady); end
    total++; if (viol != 0) begin bad++; $display("FAIL empty_cycle: %0d bad cycles, first %s", viol, first_msg); end
  endtask

  task automatic test_random();
    bq_t         e;
    bit          to, hold, cl_sent, cv, cl, br;
    int          n, idx, cyc;
    logic [11:0] code;
    for (int r = 0; r < 8; r++) begin
      apply_reset();
      n = $urandom_range(1, 14);
      idx = 0; hold = 0; cl_sent = 0; cyc = 0;
      code = 12'($urandom);
      while (cyc < 600 && !(idx == n && cl_sent)) begin
        br = ($urandom_range(0, 3) != 0);
        if (idx < n) begin
          cv = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
          cl = !cl_sent && (idx == n - 1) && cv && ($urandom_range(0, 1) == 1);
          tick(code, cv, cl, br);
          if (cl) cl_sent = 1;
          if (t_acc) begin idx++; code = 12'($urandom); hold = 0; end
          else hold = cv;
        end else begin
          tick(12'h000, 0, 1, br);
          cl_sent = 1;
        end
        cyc++;
      end
      drain(1, to);
      e = pack(sent);
      total++; if (to || sent.size() != n) begin
        bad++; $display("FAIL rnd%0d_flow: accepted %0d want %0d, timeout %b", r, sent.size(), n, to); end
      total++; if (!same(got, e)) begin bad++; $display("FAIL rnd%0d_bytes: got %s want %s", r, qstr(got), qstr(e)); end
      total++; if (bus.ByteCount !== CNT_W'(e.size())) begin
        bad++; $display("FAIL rnd%0d_cnt: got %0d want %0d", r, bus.ByteCount, e.size()); end
      total++; if (n_done != 1) begin bad++; $display("FAIL rnd%0d_done: got %0d pulses want 1", r, n_done); end
      total++; if (viol != 0) begin bad++; $display("FAIL rnd%0d_cycle: %0d bad cycles, first %s", r, viol, first_msg); end
    end
  endtask

  initial begin
    drive_idle();
    model_clear();
    test_reset();
    test_two_codes();
    test_pad();
    test_back_to_back();
    test_close_pending();
    test_async_reset();
    test_close_empty();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
